// File: rtl/bitcount_arbiter_ctrl.sv
// Round-robin controller that shares one ones-counter datapath between two requesters.
// It loads the winner's operand, walks the shift/increment loop, then returns the count with a done pulse.
module bitcount_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             Ais0,
  input  logic             a0,
  input  logic [CNT_W-1:0] result,
  output logic [WIDTH-1:0] A,
  output logic             load,
  output logic             inc,
  output logic             shift,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;
  logic   owner;
  logic   ptr;
  logic   winner;

  // On a tie, the requester that was not served last gets the datapath.
  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~ptr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      grant <= 2'b00;
      count <= '0;
      ptr   <= 1'b1;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            grant <= winner ? 2'b10 : 2'b01;
          end
        end
        RUN: begin
          if (Ais0) count <= result;
        end
        DONE: begin
          ptr   <= owner;
          grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Shift and increment share a cycle in RUN; the loop ends once the operand register is empty.
  always_comb begin
    state_next = state;
    A          = '0;
    load       = 1'b0;
    inc        = 1'b0;
    shift      = 1'b0;
    done       = 2'b00;
    case (state)
      IDLE: begin
        if (|req) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        A          = owner ? data1 : data0;
        state_next = RUN;
      end
      RUN: begin
        if (Ais0) begin
          state_next = DONE;
        end else begin
          shift = 1'b1;
          inc   = a0;
        end
      end
      DONE: begin
        done       = owner ? 2'b10 : 2'b01;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bitcount_arbiter_ctrl.sv
// Bench for bitcount_arbiter_ctrl: drives a ones-counter datapath model and checks against an operation-level model.
module tb_bitcount_arbiter_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] data0, data1;
  logic             Ais0, a0;
  logic [CNT_W-1:0] result;
  logic [WIDTH-1:0] A;
  logic             load, inc, shift;
  logic [1:0]       grant, done;
  logic [CNT_W-1:0] count;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  bitcount_arbiter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .Ais0(Ais0), .a0(a0), .result(result), .A(A), .load(load), .inc(inc),
    .shift(shift), .grant(grant), .done(done), .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ones-counter datapath the controller sequences.
  logic [WIDTH-1:0] dp_a;
  logic [CNT_W-1:0] dp_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_a   <= '0;
      dp_cnt <= '0;
    end else if (load) begin
      dp_a   <= A;
      dp_cnt <= '0;
    end else begin
      if (shift) dp_a <= dp_a >> 1;
      if (inc) dp_cnt <= dp_cnt + 1'b1;
    end
  end
  assign Ais0   = (dp_a == '0);
  assign a0     = dp_a[0];
  assign result = dp_cnt;

  // Operation-level model: k counts edges since the request was accepted.
  bit               m_active;
  int               m_k, m_owner, m_p, m_ptr, m_count;
  logic [WIDTH-1:0] m_op;

  function automatic int top_bit(input logic [WIDTH-1:0] v);
    for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_k = 0; m_owner = 0; m_p = 0; m_ptr = 1; m_count = 0; m_op = '0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        if (req == 2'b01) m_owner = 0;
        else if (req == 2'b10) m_owner = 1;
        else m_owner = (m_ptr == 0) ? 1 : 0;
        m_op     = (m_owner == 1) ? data1 : data0;
        m_p      = top_bit(m_op);
        m_k      = 0;
        m_active = 1;
      end
    end else begin
      m_k++;
      if (m_k == m_p + 2) m_count = $countones(m_op);
      if (m_k == m_p + 3) begin
        m_active = 0;
        m_ptr    = m_owner;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every cycle, one time unit after the rising edge.
  always @(posedge clk) begin
    logic [31:0] e_grant, e_done, e_a;
    logic        e_load, e_shift, e_inc;
    #1;
    e_grant = m_active ? (32'd1 << m_owner) : 32'd0;
    e_load  = m_active && (m_k == 0);
    e_a     = e_load ? {24'd0, m_op} : 32'd0;
    e_shift = m_active && (m_k >= 1) && (m_k <= m_p);
    e_inc   = 1'b0;
    if (e_shift) e_inc = m_op[m_k-1];
    e_done  = (m_active && (m_k == m_p + 2)) ? (32'd1 << m_owner) : 32'd0;
    checkOutput("busy",  {31'd0, busy},  {31'd0, m_active});
    checkOutput("grant", {30'd0, grant}, e_grant);
    checkOutput("load",  {31'd0, load},  {31'd0, e_load});
    checkOutput("A",     {24'd0, A},     e_a);
    checkOutput("shift", {31'd0, shift}, {31'd0, e_shift});
    checkOutput("inc",   {31'd0, inc},   {31'd0, e_inc});
    checkOutput("done",  {30'd0, done},  e_done);
    checkOutput("count", {28'd0, count}, m_count);
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    @(negedge clk);
    req   = r;
    data0 = d0;
    data1 = d1;
  endtask

  // Counts edges from the first one after the call until done shows; optionally drops req mid-way.
  task automatic waitDone(output logic [1:0] seen, output int edges, input int drop_after);
    edges = 0;
    seen  = 2'b00;
    while (edges < 40 && seen == 2'b00) begin
      @(posedge clk);
      edges++;
      #1;
      seen = done;
      if (drop_after > 0 && edges == drop_after) req = 2'b00;
    end
    if (seen == 2'b00) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic singleOp(input string name, input logic [1:0] r, input logic [WIDTH-1:0] d0,
                          input logic [WIDTH-1:0] d1, input int exp_lat, input int exp_cnt, input int drop_after);
    logic [1:0] seen;
    int         edges;
    applyStimulus(r, d0, d1);
    waitDone(seen, edges, drop_after);
    checkOutput({name, "_done"},    {30'd0, seen},  {30'd0, r});
    checkOutput({name, "_latency"}, edges - 1,      exp_lat);
    checkOutput({name, "_count"},   {28'd0, count}, exp_cnt);
    applyStimulus(2'b00, d0, d1);
  endtask

  initial begin
    logic [1:0] seen;
    int         edges;
    reset = 1'b0;
    req   = 2'b00;
    data0 = '0;
    data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  {31'd0, busy},  32'd0);
    checkOutput("reset_grant", {30'd0, grant}, 32'd0);
    checkOutput("reset_count", {28'd0, count}, 32'd0);
    @(negedge clk) reset = 1'b1;

    singleOp("aa_r0", 2'b01, 8'b10101010, 8'h00, 10, 4, 0);
    singleOp("zero_r1", 2'b10, 8'h00, 8'h00, 2, 0, 0);
    singleOp("ff_r1", 2'b10, 8'h00, 8'hFF, 10, 8, 0);

    // Both held from reset: grants must alternate 0,1,0.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    applyStimulus(2'b11, 8'h0F, 8'h81);
    waitDone(seen, edges, 0);
    checkOutput("tie1_done",  {30'd0, seen},  32'd1);
    checkOutput("tie1_count", {28'd0, count}, 32'd4);
    waitDone(seen, edges, 0);
    checkOutput("tie2_done",  {30'd0, seen},  32'd2);
    checkOutput("tie2_count", {28'd0, count}, 32'd2);
    waitDone(seen, edges, 0);
    checkOutput("tie3_done",  {30'd0, seen},  32'd1);
    checkOutput("tie3_count", {28'd0, count}, 32'd4);
    applyStimulus(2'b00, 8'h0F, 8'h81);

    // Requester 0 arrives while requester 1 is mid-loop.
    applyStimulus(2'b10, 8'h00, 8'h81);
    repeat (4) @(posedge clk);
    @(negedge clk);
    req   = 2'b11;
    data0 = 8'h03;
    @(posedge clk);
    #1;
    checkOutput("late_grant", {30'd0, grant}, 32'd2);
    waitDone(seen, edges, 0);
    checkOutput("late1_done",  {30'd0, seen},  32'd2);
    checkOutput("late1_count", {28'd0, count}, 32'd2);
    applyStimulus(2'b01, 8'h03, 8'h81);
    waitDone(seen, edges, 0);
    checkOutput("late0_done",  {30'd0, seen},  32'd1);
    checkOutput("late0_count", {28'd0, count}, 32'd2);
    applyStimulus(2'b00, 8'h03, 8'h81);

    // Abort mid-loop with reset.
    singleOp("pre_abort", 2'b10, 8'h00, 8'h00, 2, 0, 0);
    applyStimulus(2'b01, 8'b11110000, 8'h00);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checkOutput("abort_busy",  {31'd0, busy},  32'd0);
    checkOutput("abort_grant", {30'd0, grant}, 32'd0);
    checkOutput("abort_done",  {30'd0, done},  32'd0);
    checkOutput("abort_count", {28'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    repeat (5) @(posedge clk);
    singleOp("rerun", 2'b01, 8'b11110000, 8'h00, 10, 4, 0);

    // Requester drops req while its operation is still looping.
    singleOp("drop", 2'b01, 8'b00000011, 8'h00, 4, 2, 3);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitcount_arbiter_ctrl.md
Name: bitcount_arbiter_ctrl

Overview:
ASMD controller that sequences the 8-bit ones-counter datapath (load/inc/shift with Ais0/a0 status) and shares it between two requesters. Arbitration is round-robin; one operation is in flight at a time. The winner's operand is loaded, the FSM walks the shift/increment loop until the operand is exhausted, then the bit count is returned with a one-cycle done pulse. Sits between two client blocks and one counter datapath instance.

Parameters:
WIDTH, 8, operand width in bits; drives the datapath A bus.
CNT_W, 4, count width; must hold values 0..WIDTH.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
req  input  2  per-requester request; req[i] held high until done[i]
data0  input  WIDTH  requester 0 operand; stable while req[0] high
data1  input  WIDTH  requester 1 operand; stable while req[1] high
Ais0  input  1  datapath status: shifted operand register == 0
a0  input  1  datapath status: bit 0 of shifted operand register
result  input  CNT_W  datapath running count
A  output  WIDTH  operand to datapath; winner's data in LOAD, else 0
load  output  1  datapath load strobe
inc  output  1  datapath increment strobe
shift  output  1  datapath shift strobe
grant  output  2  one-hot owner of datapath, high from LOAD through DONE
done  output  2  one-cycle completion pulse to owner
count  output  CNT_W  registered bit count, updated on entry to DONE, held until next DONE
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, grant=0, done=0, count=0, busy=0, load/inc/shift=0, A=0, last-served pointer=1 (requester 0 wins first tie).
- States: IDLE, LOAD, RUN, DONE. Strobes are Moore/Mealy combinational from state and status; grant, count, pointer are registered.
- IDLE: if any req bit high, register owner and grant, go LOAD. Single requester wins outright; both high -> requester != last-served pointer wins. No req -> stay.
- LOAD: load=1, A=data[owner]; next state RUN (datapath clears result and captures A on this edge).
- RUN: if Ais0 -> go DONE, no strobes. Else shift=1, inc=a0 (same cycle, both applied), stay RUN.
- DONE: done[owner]=1 for exactly one cycle; count<=result on entry; pointer<=owner; grant cleared on exit; next state IDLE.
- Latency: with p = index of highest set bit + 1 (p=0 for operand 0), DONE is entered on the (p+2)th rising edge after the edge that samples req in IDLE; RUN lasts p+1 cycles. Max WIDTH+1 RUN cycles.
- Requester must drop req the cycle after done; req still high in IDLE is treated as a new request (and, if other req also high, loses the tie to the other).
- req dropped mid-operation: operation completes, done still pulses, count still updated.
- Request from the non-owner during LOAD/RUN/DONE: ignored until IDLE, then arbitrated normally.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, no done pulse; datapath state is irrelevant since the next LOAD clears it.
- Never assert load together with inc or shift.

Test Plan:
- Reset then req=01, data0=8'b10101010 -> grant=01, one load cycle, RUN 9 cycles with inc on 4 of them, done=01 pulse on 10th edge after sampling, count=4.
- req=10, data1=8'h00 -> RUN one cycle with no strobes, done=10 on 2nd edge after sampling, count=0; data1=8'hFF -> count=8, RUN 9 cycles.
- Both req high from reset -> requester 0 served first (count of data0), then requester 1 without idle gap beyond one IDLE cycle; repeat with both held -> grants alternate 01,10,01.
- req[0] raised while requester 1 in RUN -> no grant change until DONE; requester 0 granted next IDLE.
- reset pulsed low mid-RUN (data0=8'b11110000) -> busy=0, grant=0, done never pulses, count unchanged; re-request yields count=4.
- Requester 0 drops req in RUN with data0=8'b00000011 -> done[0] still pulses, count=2.
